// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - operation/result handshake bundle for the pipelined barrel shifter
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [AMT_W-1:0] in_amt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_carry;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_amt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_carry, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_amt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_carry, out_zero, out_tag
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - handshaked shift/rotate unit with carry and zero flags
module pipelined_barrel_shifter #(
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipelined_barrel_shifter_if.slave   bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int SPLIT  = (PIPE_STAGES == 2) ? LEVELS / 2 : 0;

    typedef struct packed {
        logic [WIDTH-1:0]  val;
        logic              carry;
        logic [LEVELS-1:0] amt;
        logic              left;
        logic              rot;
        logic              arith;
        logic [TAG_W-1:0]  tag;
    } mid_t;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // Left ops run in the bit-reversed domain, so every level is a right shift and the
    // carry is always the last bit to fall off the bottom of the current level.
    function automatic logic [WIDTH:0] run_levels(
        input logic [WIDTH-1:0]  v_in,
        input logic              c_in,
        input logic [LEVELS-1:0] amt,
        input logic              rot,
        input logic              arith,
        input int                lo,
        input int                hi
    );
        logic [WIDTH-1:0] v;
        logic             c;
        v = v_in;
        c = c_in;
        for (int k = 0; k < LEVELS; k++) begin
            if (k >= lo && k < hi && amt[k]) begin
                c = |(v & (WIDTH'(1) << ((1 << k) - 1)));
                if (rot)
                    v = (v >> (1 << k)) | (v << (WIDTH - (1 << k)));
                else if (arith)
                    v = $signed(v) >>> (1 << k);
                else
                    v = v >> (1 << k);
            end
        end
        return {c, v};
    endfunction

    logic [2:0]        op;
    logic              f_left, f_rot, f_arith, f_pass;
    logic [WIDTH-1:0]  a_dom;
    logic [LEVELS-1:0] amt_eff;
    logic [WIDTH:0]    r1;
    mid_t              front;

    always_comb begin
        op      = bus.in_op;
        f_left  = (op == 3'b100) || (op == 3'b110);
        f_rot   = (op == 3'b010) || (op == 3'b110);
        f_arith = (op == 3'b001);
        f_pass  = (op == 3'b011) || (op == 3'b101) || (op == 3'b111);
        a_dom   = f_left ? bit_rev(bus.in_a) : bus.in_a;
        amt_eff = f_pass ? '0 : bus.in_amt;
        r1      = run_levels(a_dom, 1'b0, amt_eff, f_rot, f_arith, 0, SPLIT);
        front.val   = r1[WIDTH-1:0];
        front.carry = r1[WIDTH];
        front.amt   = amt_eff;
        front.left  = f_left;
        front.rot   = f_rot;
        front.arith = f_arith;
        front.tag   = bus.in_tag;
    end

    logic out_valid_r;
    logic out_load_ok;
    logic mid_valid;
    mid_t mid;
    logic in_ready;

    assign out_load_ok  = ~out_valid_r | bus.out_ready;
    assign bus.in_ready = in_ready;

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic mid_adv;
            assign mid_adv  = mid_valid & out_load_ok;
            assign in_ready = ~mid_valid | mid_adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mid_valid <= 1'b0;
                    mid       <= '0;
                end else begin
                    if (in_ready) mid_valid <= bus.in_valid;
                    if (bus.in_valid && in_ready) mid <= front;
                end
            end
        end else begin : g_one_stage
            assign mid_valid = bus.in_valid;
            assign mid       = front;
            assign in_ready  = out_load_ok;
        end
    endgenerate

    logic [WIDTH:0]   r2;
    logic [WIDTH-1:0] back_y;
    logic             back_carry;
    logic             back_zero;

    always_comb begin
        r2         = run_levels(mid.val, mid.carry, mid.amt, mid.rot, mid.arith, SPLIT, LEVELS);
        back_y     = mid.left ? bit_rev(r2[WIDTH-1:0]) : r2[WIDTH-1:0];
        back_carry = r2[WIDTH];
        back_zero  = (back_y == '0);
    end

    logic [WIDTH-1:0] out_y_r;
    logic             out_carry_r;
    logic             out_zero_r;
    logic [TAG_W-1:0] out_tag_r;

    // Result fields only load on a real transfer so they hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_y_r     <= '0;
            out_carry_r <= 1'b0;
            out_zero_r  <= 1'b0;
            out_tag_r   <= '0;
        end else begin
            if (out_load_ok) out_valid_r <= mid_valid;
            if (mid_valid && out_load_ok) begin
                out_y_r     <= back_y;
                out_carry_r <= back_carry;
                out_zero_r  <= back_zero;
                out_tag_r   <= mid.tag;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_y     = out_y_r;
    assign bus.out_carry = out_carry_r;
    assign bus.out_zero  = out_zero_r;
    assign bus.out_tag   = out_tag_r;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - randomized and directed bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;
    localparam int WIDTH = 16;
    localparam int PS    = 2;
    localparam int TAG_W = 4;
    localparam int AMT_W = $clog2(WIDTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .PIPE_STAGES(PS), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             c;
        logic             z;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sbq[$];
    int   out_count = 0;

    function automatic exp_t model(input logic [WIDTH-1:0] a, input int amt,
                                   input logic [2:0] op, input logic [TAG_W-1:0] tag);
        exp_t             e;
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0] sh;
        dbl   = {a, a};
        e.c   = 1'b0;
        e.tag = tag;
        case (op)
            3'b000: begin
                e.y = a >> amt;
                sh  = a >> (amt - 1);
                if (amt > 0) e.c = sh[0];
            end
            3'b001: begin
                e.y = $signed(a) >>> amt;
                sh  = a >> (amt - 1);
                if (amt > 0) e.c = sh[0];
            end
            3'b010: begin
                e.y = WIDTH'(dbl >> amt);
                if (amt > 0) e.c = e.y[WIDTH-1];
            end
            3'b100: begin
                e.y = a << amt;
                sh  = a >> (WIDTH - amt);
                if (amt > 0) e.c = sh[0];
            end
            3'b110: begin
                dbl = dbl << amt;
                e.y = dbl[2*WIDTH-1:WIDTH];
                if (amt > 0) e.c = e.y[0];
            end
            default: e.y = a;
        endcase
        e.z = (e.y == '0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (sbq.size() == 0) begin
                    check("unexpected_out", bus.out_valid, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    check("sb_y", bus.out_y, e.y);
                    check("sb_carry", bus.out_carry, e.c);
                    check("sb_zero", bus.out_zero, e.z);
                    check("sb_tag", bus.out_tag, e.tag);
                end
            end
            if (bus.in_valid && bus.in_ready)
                sbq.push_back(model(bus.in_a, int'(bus.in_amt), bus.in_op, bus.in_tag));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input int amt, input logic [2:0] op,
                         input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_amt   = AMT_W'(amt);
        bus.in_op    = op;
        bus.in_tag   = tag;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input int amt, input logic [2:0] op,
                        input logic [TAG_W-1:0] tag);
        logic acc;
        acc = 1'b0;
        drive(a, amt, op, tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
            step();
        end
        step();
        bus.in_valid = 1'b0;
        check("send_accept", acc, 1'b1);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            step();
            lat++;
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        int               amt;
        logic [2:0]       op;
        logic [WIDTH-1:0] y;
        logic             c;
        logic             z;
    } vec_t;

    vec_t vecs[10] = '{
        '{16'hF0F0, 4,  3'b000, 16'h0F0F, 1'b0, 1'b0},
        '{16'h8000, 15, 3'b001, 16'hFFFF, 1'b0, 1'b0},
        '{16'h8001, 1,  3'b100, 16'h0002, 1'b1, 1'b0},
        '{16'h0001, 1,  3'b000, 16'h0000, 1'b1, 1'b1},
        '{16'hF0F0, 4,  3'b010, 16'h0F0F, 1'b0, 1'b0},
        '{16'h8001, 1,  3'b110, 16'h0003, 1'b1, 1'b0},
        '{16'hABCD, 0,  3'b001, 16'hABCD, 1'b0, 1'b0},
        '{16'hABCD, 0,  3'b110, 16'hABCD, 1'b0, 1'b0},
        '{16'h1234, 5,  3'b011, 16'h1234, 1'b0, 1'b0},
        '{16'h0000, 3,  3'b100, 16'h0000, 1'b0, 1'b1}
    };

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               lat;
        int               c0;
        int               acc_n;
        logic             acc_prev;
        logic [WIDTH-1:0] snap;
        logic [2:0]       rop;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_amt    = '0;
        bus.in_op     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_valid", bus.out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_y", bus.out_y, '0);
        check("rst_out_carry", bus.out_carry, 1'b0);
        check("rst_out_zero", bus.out_zero, 1'b0);
        check("rst_out_tag", bus.out_tag, '0);
        step();

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].amt, vecs[i].op, TAG_W'(i));
            wait_out(lat);
            check("dir_latency", lat, PS);
            check("dir_y", bus.out_y, vecs[i].y);
            check("dir_carry", bus.out_carry, vecs[i].c);
            check("dir_zero", bus.out_zero, vecs[i].z);
            step();
        end

        c0 = out_count;
        for (int i = 0; i < 16; i++) begin
            drive(WIDTH'($urandom), i, (i % 2 == 0) ? 3'b010 : 3'b000, TAG_W'(i));
            @(negedge clk);
            check("sweep_ready", bus.in_ready, 1'b1);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (PS + 3) step();
        check("sweep_count", out_count - c0, 16);

        c0 = out_count;
        bus.out_ready = 1'b0;
        drive(16'h1111, 1, 3'b000, 4'hA);
        @(negedge clk);
        check("bp_ready_a", bus.in_ready, 1'b1);
        step();
        drive(16'h2222, 2, 3'b100, 4'hB);
        @(negedge clk);
        check("bp_ready_b", bus.in_ready, 1'b1);
        step();
        drive(16'h3333, 3, 3'b110, 4'hC);
        @(negedge clk);
        check("bp_ready_c", bus.in_ready, 1'b0);
        check("bp_valid", bus.out_valid, 1'b1);
        snap = bus.out_y;
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_ready_hold", bus.in_ready, 1'b0);
            check("bp_valid_hold", bus.out_valid, 1'b1);
            check("bp_y_stable", bus.out_y, snap);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_release", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        repeat (PS + 3) step();
        check("bp_count", out_count - c0, 3);

        acc_n    = 0;
        acc_prev = 1'b0;
        for (int cyc = 0; cyc < 5000 && acc_n < 300; cyc++) begin
            if (!bus.in_valid || acc_prev) begin
                rop = 3'($urandom_range(0, 7));
                drive(WIDTH'($urandom), $urandom_range(0, WIDTH - 1), rop, TAG_W'($urandom));
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_prev = bus.in_valid && bus.in_ready;
            if (acc_prev) acc_n++;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (PS + 4) step();
        check("rand_accepted", acc_n, 300);
        check("rand_sb_empty", sbq.size(), 0);

        bus.out_ready = 1'b0;
        send(16'h00FF, 2, 3'b000, 4'h1);
        send(16'hFF00, 3, 3'b100, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", bus.out_valid, 1'b0);
        check("rst_mid_y", bus.out_y, '0);
        repeat (2) step();
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        c0 = out_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", bus.out_valid, 1'b0);
            step();
        end
        check("rst_no_stale_count", out_count - c0, 0);
        send(16'hF0F0, 4, 3'b000, 4'h7);
        wait_out(lat);
        check("rst_after_latency", lat, PS);
        check("rst_after_y", bus.out_y, 16'h0F0F);
        check("rst_after_tag", bus.out_tag, 4'h7);
        step();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
